// File: rtl/challenge_stream_network_if.sv
// Stream bundle for the challenge network: narrow-word challenge input, per-chain output beats.
// The master modport is the source/consumer side, the slave modport is the network itself.
interface challenge_stream_network_if #(
  parameter int N  = 64,
  parameter int W  = 16,
  parameter int K  = 4,
  parameter int CW = (K > 1) ? $clog2(K) : 1
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          mode_xor;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [CW-1:0] out_chain;
  logic          busy;

  modport master (
    output in_valid, in_data, mode_xor, out_ready,
    input  in_ready, out_valid, out_data, out_chain, busy
  );

  modport slave (
    input  in_valid, in_data, mode_xor, out_ready,
    output in_ready, out_valid, out_data, out_chain, busy
  );
endinterface

// File: rtl/challenge_stream_network.sv
// Collects an N-bit PUF challenge as N/W words, then emits K per-chain variants:
// each chain sees the challenge rotated left by k*SHIFT_STEP, optionally through the pairwise-XOR net.
module challenge_stream_network #(
  parameter int N          = 64,
  parameter int W          = 16,
  parameter int K          = 4,
  parameter int SHIFT_STEP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  challenge_stream_network_if.slave bus
);

  localparam int NW  = N / W;
  localparam int LCW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW  = (K > 1) ? $clog2(K) : 1;
  localparam int S   = SHIFT_STEP % N;

  localparam logic [LCW-1:0] LAST_WORD  = LCW'(NW - 1);
  localparam logic [CW-1:0]  LAST_CHAIN = CW'(K - 1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]     r_state;
  logic [LCW-1:0] r_loadCnt;
  logic [N-1:0]   r_rot;
  logic           r_mode;
  logic [CW-1:0]  r_chain;

  logic           w_inReady;
  logic           w_outValid;
  logic           w_inFire;
  logic           w_outFire;
  logic [N-1:0]   w_rotNext;
  logic [N-1:0]   w_xorNet;

  assign w_inReady  = (r_state == ST_LOAD);
  assign w_outValid = (r_state == ST_EMIT);
  assign w_inFire   = bus.in_valid & w_inReady;
  assign w_outFire  = w_outValid & bus.out_ready;

  // Left rotation by S as pure wiring; S = 0 degenerates to identity.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign w_rotNext[(gi + S) % N] = r_rot[gi];
  end

  // Even pairs fill the low half, odd pairs fill the upper half above the pass-through of bit 0.
  assign w_xorNet[N/2] = r_rot[0];
  for (genvar gi = 0; gi < N/2; gi++) begin : g_xorEven
    assign w_xorNet[gi] = r_rot[2*gi] ^ r_rot[2*gi+1];
  end
  for (genvar gi = 0; gi < N/2 - 1; gi++) begin : g_xorOdd
    assign w_xorNet[N/2 + 1 + gi] = r_rot[2*gi+1] ^ r_rot[2*gi+2];
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_data  = r_mode ? w_xorNet : r_rot;
  assign bus.out_chain = r_chain;
  assign bus.busy      = (r_state != ST_LOAD) || (r_loadCnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD;
      r_loadCnt <= '0;
      r_rot     <= '0;
      r_mode    <= 1'b0;
      r_chain   <= '0;
    end else if (r_state == ST_LOAD) begin
      if (w_inFire) begin
        for (int j = 0; j < NW; j++) begin
          if (r_loadCnt == LCW'(j)) begin
            r_rot[j*W +: W] <= bus.in_data;
          end
        end
        // Mode is sampled only with the final word so the whole challenge uses one mode.
        if (r_loadCnt == LAST_WORD) begin
          r_loadCnt <= '0;
          r_mode    <= bus.mode_xor;
          r_chain   <= '0;
          r_state   <= ST_EMIT;
        end else begin
          r_loadCnt <= r_loadCnt + 1'b1;
        end
      end
    end else begin
      if (w_outFire) begin
        if (r_chain == LAST_CHAIN) begin
          r_chain <= '0;
          r_state <= ST_LOAD;
        end else begin
          r_rot   <= w_rotNext;
          r_chain <= r_chain + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_challenge_stream_network.sv
// Scoreboard bench for challenge_stream_network at N=8, W=4, K=3, SHIFT_STEP=1.
// Expected beats are queued when a challenge is driven and compared as the DUT emits them.
module tb_challenge_stream_network;

  localparam int N          = 8;
  localparam int W          = 4;
  localparam int K          = 3;
  localparam int SHIFT_STEP = 1;
  localparam int NW         = N / W;
  localparam int CW         = (K > 1) ? $clog2(K) : 1;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [CW-1:0] chain;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    checks = 0;
  int    failures = 0;
  int    cycleCount = 0;
  beat_t expQ[$];
  beat_t monBeat;

  challenge_stream_network_if #(.N(N), .W(W), .K(K)) busIf();

  challenge_stream_network #(.N(N), .W(W), .K(K), .SHIFT_STEP(SHIFT_STEP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busIf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference transform written straight from the bit mapping of the XOR network.
  function automatic logic [N-1:0] modelBeat(input logic [N-1:0] c, input logic mode, input int k);
    logic [N-1:0] z;
    logic [N-1:0] y;
    int s;
    s = (k * SHIFT_STEP) % N;
    for (int i = 0; i < N; i++) z[(i + s) % N] = c[i];
    if (!mode) return z;
    y = '0;
    y[N/2] = z[0];
    for (int i = 0; i <= N - 2; i += 2) y[i/2] = z[i] ^ z[i+1];
    for (int i = 1; i <= N - 3; i += 2) y[(N + i + 1)/2] = z[i] ^ z[i+1];
    return y;
  endfunction

  task automatic pushExp(input logic [N-1:0] d, input int ch);
    beat_t b;
    b.data  = d;
    b.chain = CW'(ch);
    expQ.push_back(b);
  endtask

  task automatic pushModel(input logic [N-1:0] c, input logic mode);
    for (int k = 0; k < K; k++) pushExp(modelBeat(c, mode, k), k);
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: a beat seen valid and ready here is accepted on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && busIf.out_valid === 1'b1 && busIf.out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedBeat", 64'(busIf.out_data), 64'h1_0000_0000);
      end else begin
        monBeat = expQ.pop_front();
        checkOutput("beatData", 64'(busIf.out_data), 64'(monBeat.data));
        checkOutput("beatChain", 64'(busIf.out_chain), 64'(monBeat.chain));
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "InReady"}, 64'(busIf.in_ready), 64'd1);
    checkOutput({tag, "OutValid"}, 64'(busIf.out_valid), 64'd0);
    checkOutput({tag, "OutData"}, 64'(busIf.out_data), 64'h00);
    checkOutput({tag, "OutChain"}, 64'(busIf.out_chain), 64'd0);
    checkOutput({tag, "Busy"}, 64'(busIf.busy), 64'd0);
  endtask

  // Drives one challenge word by word; mode_xor is inverted on all but the last word.
  task automatic applyStimulus(input logic [N-1:0] ch, input logic mode, input bit gaps);
    int n;
    for (int w = 0; w < NW; w++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        busIf.in_valid = 1'b0;
        stepClk();
      end
      busIf.in_valid = 1'b1;
      busIf.in_data  = ch[w*W +: W];
      busIf.mode_xor = (w == NW - 1) ? mode : ~mode;
      n = 0;
      while (!busIf.in_ready && n < 50) begin
        stepClk();
        n++;
      end
      if (n >= 50) begin
        checkOutput("loadTimeout", 64'd0, 64'd1);
        busIf.in_valid = 1'b0;
        return;
      end
      if (w == NW - 1) checkOutput("validBeforeLast", 64'(busIf.out_valid), 64'd0);
      stepClk();
    end
    busIf.in_valid = 1'b0;
    busIf.mode_xor = 1'($urandom_range(0, 1));
    checkOutput("firstBeatValid", 64'(busIf.out_valid), 64'd1);
    checkOutput("firstBeatChain", 64'(busIf.out_chain), 64'd0);
  endtask

  task automatic drainBeats(input bit randomReady);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 200) begin
      busIf.out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      stepClk();
      n++;
    end
    busIf.out_ready = 1'b1;
    if (expQ.size() > 0) begin
      checkOutput("drainTimeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end else begin
      checkOutput("inReadyAfterLast", 64'(busIf.in_ready), 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] c1;
    logic [N-1:0] c2;
    logic [W-1:0] words[4];
    logic         modes[2];
    int           acc[4];
    int           idx;
    int           n;

    rst_n           = 1'b0;
    busIf.in_valid  = 1'b0;
    busIf.in_data   = '0;
    busIf.mode_xor  = 1'b0;
    busIf.out_ready = 1'b1;
    #3;
    checkResetValues("rst0");
    @(posedge clk);
    #2 rst_n = 1'b1;
    stepClk();

    // Partial load, then an asynchronous reset in the middle of the cycle.
    busIf.in_valid = 1'b1;
    busIf.in_data  = 4'hF;
    stepClk();
    busIf.in_valid = 1'b0;
    checkOutput("busyPartial", 64'(busIf.busy), 64'd1);
    #3 rst_n = 1'b0;
    #1 checkResetValues("rstMid");
    #2 rst_n = 1'b1;
    stepClk();

    $display("[TB] bypass");
    pushExp(8'h5A, 0); pushExp(8'hB4, 1); pushExp(8'h69, 2);
    applyStimulus(8'h5A, 1'b0, 1'b0);
    drainBeats(1'b0);

    $display("[TB] xor network");
    pushExp(8'h11, 0); pushExp(8'h21, 1); pushExp(8'h22, 2);
    applyStimulus(8'h01, 1'b1, 1'b0);
    drainBeats(1'b0);

    $display("[TB] backpressure");
    pushExp(8'h5A, 0); pushExp(8'hB4, 1); pushExp(8'h69, 2);
    applyStimulus(8'h5A, 1'b0, 1'b0);
    stepClk();
    busIf.out_ready = 1'b0;
    busIf.in_data   = 4'h7;
    for (int i = 0; i < 5; i++) begin
      busIf.in_valid = 1'(i % 2);
      checkOutput("bpValid", 64'(busIf.out_valid), 64'd1);
      checkOutput("bpData", 64'(busIf.out_data), 64'hB4);
      checkOutput("bpChain", 64'(busIf.out_chain), 64'd1);
      checkOutput("bpInReady", 64'(busIf.in_ready), 64'd0);
      stepClk();
    end
    busIf.in_valid = 1'b0;
    drainBeats(1'b0);

    $display("[TB] reset during emission");
    pushExp(8'h5A, 0); pushExp(8'hB4, 1); pushExp(8'h69, 2);
    applyStimulus(8'h5A, 1'b0, 1'b0);
    stepClk();
    #2 rst_n = 1'b0;
    expQ.delete();
    #1 checkResetValues("rstEmit");
    #2 rst_n = 1'b1;
    stepClk();
    pushExp(8'hC3, 0); pushExp(8'h87, 1); pushExp(8'h0F, 2);
    applyStimulus(8'hC3, 1'b0, 1'b0);
    drainBeats(1'b0);

    $display("[TB] back-to-back");
    c1 = N'($urandom);
    c2 = N'($urandom);
    modes[0] = 1'b0;
    modes[1] = 1'b1;
    words[0] = c1[W-1:0];
    words[1] = c1[N-1:W];
    words[2] = c2[W-1:0];
    words[3] = c2[N-1:W];
    pushModel(c1, modes[0]);
    pushModel(c2, modes[1]);
    busIf.out_ready = 1'b1;
    busIf.in_valid  = 1'b1;
    idx = 0;
    n = 0;
    while (idx < 4 && n < 100) begin
      busIf.in_data  = words[idx];
      busIf.mode_xor = (idx % 2 == 1) ? modes[idx/2] : ~modes[idx/2];
      if (busIf.in_ready) begin
        acc[idx] = cycleCount;
        idx++;
      end
      stepClk();
      n++;
    end
    busIf.in_valid = 1'b0;
    if (idx < 4) begin
      checkOutput("b2bTimeout", 64'(idx), 64'd4);
    end else begin
      checkOutput("b2bFullRate", 64'(acc[1] - acc[0]), 64'd1);
      checkOutput("b2bPeriod", 64'(acc[2] - acc[0]), 64'(NW + K));
    end
    drainBeats(1'b0);

    $display("[TB] random challenges with gaps and random ready");
    for (int t = 0; t < 4; t++) begin
      c1 = N'($urandom);
      modes[0] = 1'($urandom_range(0, 1));
      pushModel(c1, modes[0]);
      applyStimulus(c1, modes[0], 1'b1);
      drainBeats(1'b1);
    end

    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/challenge_stream_network.md
# challenge_stream_network

Sequential, parametrised successor to the combinational PUF challenge input network. It accepts an N-bit challenge as N/W narrow words over a valid/ready stream. It then emits K transformed challenges, one per PUF chain, on a second valid/ready stream. Chain k receives the challenge rotated left by (k·SHIFT_STEP) mod N, optionally passed through the pairwise-XOR network. It sits between the challenge source (host interface or LFSR) and the K-chain XOR/interpose PUF array.

## Interface
Parameters:
- N, 64: challenge width in bits; must be even and ≥ 4.
- W, 16: input word width; must divide N.
- K, 4: number of chains, i.e. output beats per challenge; K ≥ 1.
- SHIFT_STEP, 1: extra left rotation per chain, taken mod N.
- CW, max(1, clog2(K)): width of out_chain (derived).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data word is valid.
- in_ready  out  1  block accepts an input word.
- in_data  in  W  challenge word; least-significant word first.
- mode_xor  in  1  0 selects bypass (rotation only); 1 selects rotation then XOR network.
- out_valid  out  1  out_data/out_chain are valid.
- out_ready  in  1  consumer accepts the output beat.
- out_data  out  N  transformed challenge for chain out_chain.
- out_chain  out  CW  chain index, 0..K-1.
- busy  out  1  high whenever the state is not LOAD or the load counter is non-zero.

## Operation
- State machine has two states: LOAD and EMIT.
- LOAD:
  - in_ready = 1, out_valid = 0.
  - Each accepted word (in_valid & in_ready) is written to challenge register bits [W·j+W-1 : W·j], where j is the load counter. j then increments.
  - On the accept with j = N/W-1: j returns to 0, mode_xor is latched, out_chain is set to 0, and the state moves to EMIT.
- EMIT:
  - in_ready = 0, out_valid = 1. in_valid is ignored.
  - out_data = T(r), where r is the rotation register (initially the loaded challenge). out_data is a function of registers only.
  - On each accept (out_valid & out_ready):
    - If out_chain = K-1: return to LOAD, out_chain returns to 0.
    - Otherwise r rotates left by SHIFT_STEP mod N, i.e. r ← {r[N-s-1:0], r[N-1:N-s]} with s = SHIFT_STEP mod N; s = 0 leaves r unchanged. out_chain increments.
- T(z) when latched mode = 0: T(z) = z.
- T(z) when latched mode = 1, for y = T(z):
  - y[N/2] = z[0].
  - For even i in 0..N-2: y[i/2] = z[i] ^ z[i+1].
  - For odd i in 1..N-3: y[(N+i+1)/2] = z[i] ^ z[i+1].
- Reset values:
  - State LOAD, so in_ready = 1.
  - out_valid = 0, out_chain = 0.
  - Challenge/rotation register = 0, so out_data = 0.
  - Load counter = 0, latched mode = 0, busy = 0.

## Timing
- Load phase takes N/W accepted words. Minimum is N/W cycles at full rate; gaps in in_valid are tolerated.
- The last word is accepted at edge t; out_valid is 1 in the cycle following t, with chain 0 data.
- With out_ready held high, one beat is emitted per cycle. Minimum period per challenge is N/W + K cycles.
- After the chain K-1 beat is accepted at edge e, in_ready = 1 in the cycle following e.
- Backpressure: while out_valid & !out_ready, out_data and out_chain hold stable.
- W = N: single-word load. K = 1: one beat per challenge, out_chain stays 0.
- mode_xor changes during LOAD (before the last word) or during EMIT have no effect on the current challenge.
- rst_n low at any time: all state returns to reset values immediately (asynchronous), and a partial load or emission is discarded. The first edge after deassertion behaves as LOAD with j = 0.

## Test plan
All cases use N=8, W=4, K=3, SHIFT_STEP=1.
- Reset: assert rst_n = 0 mid-cycle -> outputs take reset values immediately: in_ready = 1, out_valid = 0, out_data = 8'h00, out_chain = 0, busy = 0.
- Bypass: load 4'hA then 4'h5 with mode_xor = 0, out_ready = 1 -> beats 8'h5A (chain 0), 8'hB4 (chain 1), 8'h69 (chain 2). out_valid first rises one cycle after the second word is accepted.
- XOR network: load 8'h01 (words 4'h1, 4'h0) with mode_xor = 1 -> beats 8'h11, 8'h21, 8'h22 on chains 0, 1, 2.
- Backpressure: in the bypass case, hold out_ready = 0 for 5 cycles on chain 1 -> out_valid = 1 and out_data = 8'hB4 stable throughout. in_ready stays 0, and in_valid pulses are not consumed.
- Reset mid-EMIT: pull rst_n low after the chain 0 accept, then release and load 8'hC3 in bypass -> next beats are 8'hC3, 8'h87, 8'h0F on chains 0, 1, 2, with no stale data.
- Back-to-back: two challenges, in_valid high continuously, out_ready = 1 -> in_ready returns one cycle after the chain 2 accept, giving a 5-cycle period per challenge.
